mcode_sequencer: RTL and testbench



---
 rtl/mcode_pkg.sv | 42 ++++
 rtl/mcode_rom_rf.sv | 25 ++
 rtl/mcode_sequencer.sv | 96 +++++++++
 tb/tb_mcode_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcode_pkg.sv
// Shared types and constants for the microcode sequencer and its program store.
package mcode_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned MCW   = 14;
  localparam int unsigned LCW   = 8;
  localparam int unsigned IW    = 2 + AW + MCW;

  // Machine code field positions as seen by the register-file datapath.
  localparam int unsigned RFSRC      = 13;
  localparam int unsigned RADDR1_MSB = 12;
  localparam int unsigned RADDR1_LSB = 10;
  localparam int unsigned RADDR2_MSB = 9;
  localparam int unsigned RADDR2_LSB = 7;
  localparam int unsigned WADDR_MSB  = 6;
  localparam int unsigned WADDR_LSB  = 4;
  localparam int unsigned WREN       = 3;
  localparam int unsigned ALUOP_MSB  = 2;
  localparam int unsigned ALUOP_LSB  = 1;
  localparam int unsigned OUTLOAD    = 0;

  typedef enum logic [1:0] {
    OP_SEQ  = 2'b00,
    OP_JMP  = 2'b01,
    OP_JNZ  = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [AW-1:0]   target;
    logic [MCW-1:0]  mc;
  } prog_word_t;

endpackage

// File: rtl/mcode_rom_rf.sv
// Writable program store: DEPTH x IW flop array, synchronous write, asynchronous read.
// Contents are deliberately not reset; the program survives a sequencer reset.
module mcode_rom_rf
  import mcode_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mcode_sequencer.sv
// Microcode sequencer: steps a writable microprogram and drives the register-file datapath
// with one machine code word per cycle, with jump, counted loop and halt support.
module mcode_sequencer
  import mcode_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           prog_we,
  input  logic [AW-1:0]  prog_addr,
  input  logic [IW-1:0]  prog_data,
  input  logic           start,
  input  logic [LCW-1:0] loop_count,
  output logic [MCW-1:0] machine_code,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  pc
);

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [LCW-1:0] lc_q, lc_d;

  logic [IW-1:0]  rom_rdata;
  prog_word_t     cur_word;
  logic           rom_we;

  // Writes arriving while the program runs are dropped so the running code never changes.
  assign rom_we = prog_we && (state_q != S_RUN);

  mcode_rom_rf u_rom (
    .clk     (clk),
    .we_i    (rom_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (rom_rdata)
  );

  assign cur_word = prog_word_t'(rom_rdata);
  assign pc       = pc_q;

  // State, program counter and loop counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lc_q    <= lc_d;
    end
  end

  // Next-state: launch on start from IDLE, execute the current word's opcode in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lc_d    = lc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          lc_d    = loop_count;
        end
      end
      S_RUN: begin
        unique case (cur_word.op)
          OP_SEQ: pc_d = pc_q + AW'(1);  // DEPTH is a power of two, so this wraps
          OP_JMP: pc_d = cur_word.target;
          OP_JNZ: begin
            // lc only decrements when non-zero, so it cannot underflow.
            if (lc_q != '0) begin
              lc_d = lc_q - LCW'(1);
              pc_d = cur_word.target;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end
          OP_HALT: state_d = S_DONE;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: datapath sees a NOP (all zeros) whenever the program is not running.
  always_comb begin
    busy         = (state_q == S_RUN);
    done         = (state_q == S_DONE);
    machine_code = busy ? cur_word.mc : '0;
  end

endmodule

// File: tb/tb_mcode_sequencer.sv
// Directed self-checking bench for mcode_sequencer.
module tb_mcode_sequencer;
  import mcode_pkg::*;

  logic           clk;
  logic           reset;
  logic           prog_we;
  logic [AW-1:0]  prog_addr;
  logic [IW-1:0]  prog_data;
  logic           start;
  logic [LCW-1:0] loop_count;
  logic [MCW-1:0] machine_code;
  logic           busy;
  logic           done;
  logic [AW-1:0]  pc;

  int checks = 0;
  int errors = 0;

  mcode_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .loop_count   (loop_count),
    .machine_code (machine_code),
    .busy         (busy),
    .done         (done),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [1:0] op, input logic [3:0] tgt,
                      input logic [13:0] mc);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = {op, tgt, mc};
    tick();
    prog_we   = 1'b0;
  endtask

  // Pulse start for one cycle; returns during the first RUN cycle.
  task automatic start_run(input logic [7:0] lc);
    start      = 1'b1;
    loop_count = lc;
    tick();
    start      = 1'b0;
  endtask

  task automatic load_loop_prog();
    load(4'd0, 2'b00, 4'd0, 14'h0111);
    load(4'd1, 2'b10, 4'd0, 14'h0222);
    load(4'd2, 2'b11, 4'd0, 14'h0333);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0 || machine_code !== 14'h0000) begin
      errors++;
      $display("FAIL reset_async busy=%b done=%b pc=%0d mc=%h expected 0 0 0 0000",
               busy, done, pc, machine_code);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || machine_code !== 14'h0000) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b mc=%h expected 0 0 0000", busy, done,
               machine_code);
    end
  endtask

  task automatic test_straight();
    logic [13:0] exp [3] = '{14'h1234, 14'h0ABC, 14'h2008};
    load(4'd0, 2'b00, 4'd0, 14'h1234);
    load(4'd1, 2'b00, 4'd0, 14'h0ABC);
    load(4'd2, 2'b11, 4'd0, 14'h2008);
    start_run(8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (machine_code !== exp[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL straight[%0d] mc=%h busy=%b done=%b expected mc=%h busy=1 done=0",
                 i, machine_code, busy, done, exp[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || machine_code !== 14'h0000) begin
      errors++;
      $display("FAIL straight_done done=%b busy=%b mc=%h expected 1 0 0000", done, busy,
               machine_code);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || machine_code !== 14'h0000) begin
      errors++;
      $display("FAIL straight_after done=%b busy=%b mc=%h expected 0 0 0000", done, busy,
               machine_code);
    end
  endtask

  task automatic test_loop();
    logic [13:0] exp2 [7] = '{14'h0111, 14'h0222, 14'h0111, 14'h0222, 14'h0111, 14'h0222,
                              14'h0333};
    logic [13:0] exp0 [3] = '{14'h0111, 14'h0222, 14'h0333};
    load_loop_prog();
    start_run(8'd2);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (machine_code !== exp2[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL loop2[%0d] mc=%h busy=%b expected mc=%h busy=1", i, machine_code,
                 busy, exp2[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop2_done done=%b busy=%b expected 1 0", done, busy);
    end
    tick();
    start_run(8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (machine_code !== exp0[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL loop0[%0d] mc=%h busy=%b expected mc=%h busy=1", i, machine_code,
                 busy, exp0[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop0_done done=%b busy=%b expected 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_wrap_jmp();
    logic [3:0]  exp_pc [4] = '{4'd0, 4'd15, 4'd0, 4'd15};
    logic [13:0] exp_mc [4] = '{14'h0005, 14'h0F0F, 14'h0005, 14'h0F0F};
    // First run: JMP to the last word, which wraps back to 0; no HALT, so it spins.
    load(4'd15, 2'b00, 4'd0, 14'h0F0F);
    load(4'd0, 2'b01, 4'd15, 14'h0005);
    start_run(8'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc !== exp_pc[i] || machine_code !== exp_mc[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL wrap[%0d] pc=%0d mc=%h busy=%b expected pc=%0d mc=%h busy=1", i, pc,
                 machine_code, busy, exp_pc[i], exp_mc[i]);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Second run: HALT at address 0 after the wrap program is replaced.
    load(4'd0, 2'b11, 4'd0, 14'h0001);
    start_run(8'd0);
    checks++;
    if (pc !== 4'd0 || machine_code !== 14'h0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_at0 pc=%0d mc=%h busy=%b expected pc=0 mc=0001 busy=1", pc,
               machine_code, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pc !== 4'd0) begin
      errors++;
      $display("FAIL halt_at0_done done=%b pc=%0d expected done=1 pc=0", done, pc);
    end
    tick();
  endtask

  task automatic test_ignored();
    logic [13:0] exp2 [7] = '{14'h0111, 14'h0222, 14'h0111, 14'h0222, 14'h0111, 14'h0222,
                              14'h0333};
    logic [13:0] exp0 [3] = '{14'h0111, 14'h0222, 14'h0333};
    load_loop_prog();
    start_run(8'd2);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (machine_code !== exp2[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL ignored_run[%0d] mc=%h busy=%b expected mc=%h busy=1", i,
                 machine_code, busy, exp2[i]);
      end
      if (i == 1) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = {2'b11, 4'd0, 14'h3FFF};
      end else if (i == 2) begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignored_done done=%b expected 1", done);
    end
    tick();
    start_run(8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (machine_code !== exp0[i]) begin
        errors++;
        $display("FAIL ignored_rerun[%0d] mc=%h expected %h", i, machine_code, exp0[i]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [13:0] exp1 [5] = '{14'h0111, 14'h0222, 14'h0111, 14'h0222, 14'h0333};
    start_run(8'd2);
    tick();
    checks++;
    if (machine_code !== 14'h0222 || pc !== 4'd1) begin
      errors++;
      $display("FAIL abort_pre mc=%h pc=%0d expected 0222 1", machine_code, pc);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (machine_code !== 14'h0000 || busy !== 1'b0 || pc !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async mc=%h busy=%b pc=%0d done=%b expected 0000 0 0 0",
               machine_code, busy, pc, done);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_nodone[%0d] done=%b busy=%b expected 0 0", i, done, busy);
      end
      tick();
    end
    start_run(8'd1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (machine_code !== exp1[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_rerun[%0d] mc=%h busy=%b expected mc=%h busy=1", i,
                 machine_code, busy, exp1[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun_done done=%b expected 1", done);
    end
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    start      = 1'b0;
    loop_count = '0;
    test_reset();
    test_straight();
    test_loop();
    test_wrap_jmp();
    test_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
